// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types, widths and line-alignment helper for the L2 arbiter
package l2_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LINE_OFF_BITS = 5;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {ICACHE, DCACHE} req_id_t;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/l2_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick (req[0]=icache, req[1]=dcache) -> gnt, any, prio_nxt
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    prio,
  input  logic       advance,
  output req_id_t    gnt,
  output logic       any,
  output req_id_t    prio_nxt
);
  always_comb begin
    any = |req;
    gnt = &req ? prio : (req[1] ? DCACHE : ICACHE);
    prio_nxt = (advance && any) ? (gnt == ICACHE ? DCACHE : ICACHE) : prio;
  end
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin share of one L2 port between icache fills and dcache fills/write-backs; ports ic_*, dc_* requesters, l2_* memory side
module l2_arbiter
  import l2_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [LINE_W-1:0] ic_block,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_valid,
  output logic [LINE_W-1:0] dc_block,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_stall,
  input  logic [LINE_W-1:0] l2_block
);
  state_t state_q, state_d;
  req_id_t prio_q, prio_nxt, owner_q, owner_d, gnt;
  logic any;
  logic l2_req_q, l2_req_d, l2_we_q, l2_we_d, ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d, ic_block_q, ic_block_d, dc_block_q, dc_block_d;
  rr_arb2 u_rr (
    .req      ({dc_req, ic_req}),
    .prio     (prio_q),
    .advance  (state_q == IDLE),
    .gnt      (gnt),
    .any      (any),
    .prio_nxt (prio_nxt)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    l2_req_d = l2_req_q;
    l2_we_d = l2_we_q;
    l2_addr_d = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    ic_block_d = ic_block_q;
    dc_block_d = dc_block_q;
    ic_valid_d = 1'b0;
    dc_valid_d = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        owner_d = gnt;
        l2_req_d = 1'b1;
        l2_we_d = (gnt == DCACHE) && dc_we;
        l2_addr_d = line_align(gnt == DCACHE ? dc_addr : ic_addr);
        l2_wdata_d = gnt == DCACHE ? dc_wdata : '0;
        state_d = BUSY;
      end
      BUSY: if (!l2_stall) begin
        l2_req_d = 1'b0;
        ic_valid_d = owner_q == ICACHE;
        dc_valid_d = owner_q == DCACHE;
        ic_block_d = (owner_q == ICACHE && !l2_we_q) ? l2_block : ic_block_q;
        dc_block_d = (owner_q == DCACHE && !l2_we_q) ? l2_block : dc_block_q;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= ICACHE;
      owner_q <= ICACHE;
      l2_req_q <= 1'b0;
      l2_we_q <= 1'b0;
      l2_addr_q <= '0;
      l2_wdata_q <= '0;
      ic_block_q <= '0;
      dc_block_q <= '0;
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_nxt;
      owner_q <= owner_d;
      l2_req_q <= l2_req_d;
      l2_we_q <= l2_we_d;
      l2_addr_q <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      ic_block_q <= ic_block_d;
      dc_block_q <= dc_block_d;
      ic_valid_q <= ic_valid_d;
      dc_valid_q <= dc_valid_d;
    end
  end
  assign l2_req = l2_req_q;
  assign l2_we = l2_we_q;
  assign l2_addr = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign ic_valid = ic_valid_q;
  assign dc_valid = dc_valid_q;
  assign ic_block = ic_block_q;
  assign dc_block = dc_block_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed self-checking bench for l2_arbiter
module tb_l2_arbiter;
  import l2_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, l2_stall = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0, dc_addr = '0;
  logic [LINE_W-1:0] dc_wdata = '0, l2_block = '0;
  logic ic_valid, dc_valid, l2_req, l2_we;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] ic_block, dc_block, l2_wdata;
  int n_checks = 0;
  int n_fail = 0;
  l2_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_block(ic_block),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_valid(dc_valid), .dc_block(dc_block),
    .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_stall(l2_stall), .l2_block(l2_block)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL reset_l2_req got=%b exp=0", l2_req); end
    n_checks++; if (l2_we !== 1'b0) begin n_fail++; $display("FAIL reset_l2_we got=%b exp=0", l2_we); end
    n_checks++; if (ic_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ic_valid got=%b exp=0", ic_valid); end
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dc_valid got=%b exp=0", dc_valid); end
    n_checks++; if (l2_addr !== '0) begin n_fail++; $display("FAIL reset_l2_addr got=%h exp=0", l2_addr); end
    n_checks++; if (l2_wdata !== '0) begin n_fail++; $display("FAIL reset_l2_wdata got=%h exp=0", l2_wdata); end
    n_checks++; if (ic_block !== '0) begin n_fail++; $display("FAIL reset_ic_block got=%h exp=0", ic_block); end
    n_checks++; if (dc_block !== '0) begin n_fail++; $display("FAIL reset_dc_block got=%h exp=0", dc_block); end
  endtask
  task automatic test_ic_fill();
    logic [LINE_W-1:0] pat;
    pat = {32{8'hA5}};
    ic_addr = 32'h0000_1234;
    l2_block = pat;
    l2_stall = 1'b0;
    ic_req = 1'b1;
    step();
    n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL icfill_l2_req got=%b exp=1", l2_req); end
    n_checks++; if (l2_we !== 1'b0) begin n_fail++; $display("FAIL icfill_l2_we got=%b exp=0", l2_we); end
    n_checks++; if (l2_addr !== 32'h0000_1220) begin n_fail++; $display("FAIL icfill_l2_addr got=%h exp=00001220", l2_addr); end
    n_checks++; if (ic_valid !== 1'b0) begin n_fail++; $display("FAIL icfill_early_valid got=%b exp=0", ic_valid); end
    step();
    n_checks++; if (ic_valid !== 1'b1) begin n_fail++; $display("FAIL icfill_ic_valid got=%b exp=1", ic_valid); end
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL icfill_l2_req_drop got=%b exp=0", l2_req); end
    n_checks++; if (ic_block !== pat) begin n_fail++; $display("FAIL icfill_ic_block got=%h exp=%h", ic_block, pat); end
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL icfill_dc_valid got=%b exp=0", dc_valid); end
    ic_req = 1'b0;
    step();
    n_checks++; if (ic_valid !== 1'b0) begin n_fail++; $display("FAIL icfill_pulse_width got=%b exp=0", ic_valid); end
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL icfill_dc_valid_after got=%b exp=0", dc_valid); end
  endtask
  task automatic test_dc_writeback_stall();
    dc_req = 1'b1;
    dc_we = 1'b1;
    dc_addr = 32'h8000_0044;
    dc_wdata = 256'h1;
    l2_block = {32{8'h5A}};
    l2_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL wb_l2_req[%0d] got=%b exp=1", i, l2_req); end
      n_checks++; if (l2_we !== 1'b1) begin n_fail++; $display("FAIL wb_l2_we[%0d] got=%b exp=1", i, l2_we); end
      n_checks++; if (l2_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL wb_l2_addr[%0d] got=%h exp=80000040", i, l2_addr); end
      n_checks++; if (l2_wdata !== 256'h1) begin n_fail++; $display("FAIL wb_l2_wdata[%0d] got=%h exp=1", i, l2_wdata); end
      n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL wb_early_valid[%0d] got=%b exp=0", i, dc_valid); end
      if (i == 3) l2_stall = 1'b0;
    end
    step();
    n_checks++; if (dc_valid !== 1'b1) begin n_fail++; $display("FAIL wb_dc_valid got=%b exp=1", dc_valid); end
    n_checks++; if (ic_valid !== 1'b0) begin n_fail++; $display("FAIL wb_ic_valid got=%b exp=0", ic_valid); end
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL wb_l2_req_drop got=%b exp=0", l2_req); end
    n_checks++; if (dc_block !== '0) begin n_fail++; $display("FAIL wb_dc_block got=%h exp=0", dc_block); end
    dc_req = 1'b0;
    dc_we = 1'b0;
    step();
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL wb_pulse_width got=%b exp=0", dc_valid); end
  endtask
  task automatic test_fairness();
    logic [7:0] exp_req, exp_iv, exp_dv;
    logic [LINE_W-1:0] pat;
    exp_req = 8'b0100_1001;
    exp_iv = 8'b1000_0010;
    exp_dv = 8'b0001_0000;
    pat = {8{32'h1111_2222}};
    apply_reset();
    ic_addr = 32'h100;
    dc_addr = 32'h200;
    dc_we = 1'b0;
    l2_block = pat;
    l2_stall = 1'b0;
    ic_req = 1'b1;
    dc_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++; if (l2_req !== exp_req[k]) begin n_fail++; $display("FAIL rr_l2_req[%0d] got=%b exp=%b", k, l2_req, exp_req[k]); end
      n_checks++; if (ic_valid !== exp_iv[k]) begin n_fail++; $display("FAIL rr_ic_valid[%0d] got=%b exp=%b", k, ic_valid, exp_iv[k]); end
      n_checks++; if (dc_valid !== exp_dv[k]) begin n_fail++; $display("FAIL rr_dc_valid[%0d] got=%b exp=%b", k, dc_valid, exp_dv[k]); end
      if (exp_req[k]) begin
        n_checks++;
        if (l2_addr !== ((k == 3) ? 32'h200 : 32'h100)) begin
          n_fail++; $display("FAIL rr_l2_addr[%0d] got=%h exp=%h", k, l2_addr, (k == 3) ? 32'h200 : 32'h100);
        end
      end
    end
    n_checks++; if (dc_block !== pat) begin n_fail++; $display("FAIL rr_dc_block got=%h exp=%h", dc_block, pat); end
    ic_req = 1'b0;
    dc_req = 1'b0;
    step();
    step();
  endtask
  task automatic test_owner_change();
    ic_addr = 32'h40;
    l2_stall = 1'b1;
    ic_req = 1'b1;
    step();
    n_checks++; if (l2_addr !== 32'h40) begin n_fail++; $display("FAIL own_l2_addr got=%h exp=40", l2_addr); end
    ic_addr = 32'h80;
    ic_req = 1'b0;
    step();
    n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL own_l2_req_hold got=%b exp=1", l2_req); end
    n_checks++; if (l2_addr !== 32'h40) begin n_fail++; $display("FAIL own_l2_addr_hold got=%h exp=40", l2_addr); end
    l2_stall = 1'b0;
    step();
    n_checks++; if (ic_valid !== 1'b1) begin n_fail++; $display("FAIL own_ic_valid got=%b exp=1", ic_valid); end
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL own_dc_valid got=%b exp=0", dc_valid); end
    step();
    n_checks++; if (ic_valid !== 1'b0) begin n_fail++; $display("FAIL own_pulse_width got=%b exp=0", ic_valid); end
    step();
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL own_no_regrant got=%b exp=0", l2_req); end
  endtask
  task automatic test_async_reset();
    dc_req = 1'b1;
    dc_we = 1'b0;
    dc_addr = 32'h300;
    l2_stall = 1'b1;
    step();
    n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL arst_l2_req_pre got=%b exp=1", l2_req); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL arst_l2_req_now got=%b exp=0", l2_req); end
    n_checks++; if (l2_addr !== '0) begin n_fail++; $display("FAIL arst_l2_addr_now got=%h exp=0", l2_addr); end
    dc_req = 1'b0;
    l2_stall = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL arst_idle_l2_req[%0d] got=%b exp=0", i, l2_req); end
      n_checks++; if ({ic_valid, dc_valid} !== 2'b00) begin n_fail++; $display("FAIL arst_idle_valids[%0d] got=%b exp=00", i, {ic_valid, dc_valid}); end
    end
  endtask
  task automatic test_back_to_back();
    l2_stall = 1'b0;
    l2_block = {32{8'hC3}};
    ic_addr = 32'h500;
    ic_req = 1'b1;
    step();
    n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL b2b_first_req got=%b exp=1", l2_req); end
    step();
    n_checks++; if (ic_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got=%b exp=1", ic_valid); end
    ic_req = 1'b0;
    step();
    n_checks++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_req got=%b exp=0", l2_req); end
    ic_req = 1'b1;
    ic_addr = 32'h53F;
    l2_block = {32{8'h3C}};
    step();
    n_checks++; if (l2_req !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req got=%b exp=1", l2_req); end
    n_checks++; if (l2_addr !== 32'h520) begin n_fail++; $display("FAIL b2b_second_addr got=%h exp=520", l2_addr); end
    step();
    n_checks++; if (ic_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got=%b exp=1", ic_valid); end
    n_checks++; if (ic_block !== {32{8'h3C}}) begin n_fail++; $display("FAIL b2b_ic_block got=%h exp=%h", ic_block, {32{8'h3C}}); end
    n_checks++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dc_valid got=%b exp=0", dc_valid); end
    ic_req = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    test_ic_fill();
    test_dc_writeback_stall();
    test_fairness();
    test_owner_change();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
